vga_board_scan: RTL and testbench



---
 rtl/vga_board_scan.sv | 150 +++++++++++++++
 tb/tb_vga_board_scan.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_board_scan.sv
// VGA raster generator (one pixel every second clk) that scans an 8x8 board of palette cells
// and emits a registered palette index per pixel, with the cursor cell outlined in index 2.
module vga_board_scan #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOARD_X0 = 80,
    parameter int CELL_PX  = 60,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [2:0] wr_row,
    input  logic [2:0] wr_col,
    input  logic [2:0] wr_color,
    input  logic [2:0] cur_row,
    input  logic [2:0] cur_col,
    output logic       pix_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [2:0] color,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] BX0      = HW'(BOARD_X0);
    localparam logic [HW-1:0] BX0_PRE  = HW'(BOARD_X0 - 1);
    localparam logic [HW-1:0] BX1      = HW'(BOARD_X0 + 8 * CELL_PX);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [SW-1:0] S_LAST   = SW'(CELL_PX - 1);

    logic          tick_reg;
    logic [HW-1:0] h_reg;
    logic [VW-1:0] v_reg;
    logic [SW-1:0] sub_x_reg;
    logic [SW-1:0] sub_y_reg;
    logic [2:0]    col_reg;
    logic [2:0]    row_reg;
    logic          hsync_reg;
    logic          vsync_reg;
    logic          blank_reg;
    logic [2:0]    color_reg;
    logic          frame_start_reg;
    logic [2:0]    cells_reg [0:63];

    logic          active;
    logic          in_board;
    logic [2:0]    color_next;

    assign active   = (h_reg < H_ACT) && (v_reg < V_ACT);
    assign in_board = (h_reg >= BX0) && (h_reg < BX1);

    always_comb begin
        color_next = 3'd0;
        if (active && in_board) begin
            if (sub_x_reg == '0 || sub_y_reg == '0)
                color_next = (row_reg == cur_row && col_reg == cur_col) ? 3'd2 : 3'd1;
            else
                color_next = cells_reg[{row_reg, col_reg}];
        end
    end

    // Cell memory is written at full clk rate; the scan reads it only on tick edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) cells_reg[i] <= '0;
        end else if (wr_en) begin
            cells_reg[{wr_row, wr_col}] <= wr_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg        <= 1'b0;
            h_reg           <= '0;
            v_reg           <= '0;
            sub_x_reg       <= '0;
            col_reg         <= '0;
            sub_y_reg       <= '0;
            row_reg         <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            blank_reg       <= 1'b1;
            color_reg       <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            tick_reg        <= ~tick_reg;
            // frame_start lasts one clk even though the other outputs hold for a whole pixel
            frame_start_reg <= 1'b0;
            if (tick_reg) begin
                hsync_reg       <= ~((h_reg >= HS_START) && (h_reg < HS_END));
                vsync_reg       <= ~((v_reg >= VS_START) && (v_reg < VS_END));
                blank_reg       <= ~active;
                color_reg       <= color_next;
                frame_start_reg <= (h_reg == '0) && (v_reg == '0);

                h_reg <= (h_reg == H_LAST) ? '0 : h_reg + 1'b1;

                if (h_reg == BX0_PRE) begin
                    sub_x_reg <= '0;
                    col_reg   <= '0;
                end else if (sub_x_reg == S_LAST) begin
                    sub_x_reg <= '0;
                    col_reg   <= col_reg + 3'd1;
                end else begin
                    sub_x_reg <= sub_x_reg + 1'b1;
                end

                if (h_reg == H_LAST) begin
                    v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
                    if (v_reg == V_LAST) begin
                        sub_y_reg <= '0;
                        row_reg   <= '0;
                    end else if (sub_y_reg == S_LAST) begin
                        sub_y_reg <= '0;
                        row_reg   <= row_reg + 3'd1;
                    end else begin
                        sub_y_reg <= sub_y_reg + 1'b1;
                    end
                end
            end
        end
    end

    assign pix_tick    = tick_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign blank       = blank_reg;
    assign color       = color_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_board_scan.sv
// Scoreboard bench: a shrunken raster for frame-level behaviour plus a full-size raster for line timing.
`timescale 1ns/1ps
module tb_vga_board_scan;

    localparam int SH = 64;          // small raster: 48+4+6+6 pixels per line
    localparam int SV = 38;          // small raster: 32+2+2+2 lines per frame
    localparam int SFRAME_CLK = 2 * SH * SV;
    localparam int DH = 800;

    logic       clk;
    logic       rst_n, rst_n_d;
    logic       wr_en;
    logic [2:0] wr_row, wr_col, wr_color, cur_row, cur_col;
    logic       d_wr_en;
    logic [2:0] d_zero;

    logic       s_pix_tick, s_hsync, s_vsync, s_blank, s_frame_start;
    logic [2:0] s_color;
    logic       d_pix_tick, d_hsync, d_vsync, d_blank, d_frame_start;
    logic [2:0] d_color;

    vga_board_scan #(
        .H_ACTIVE(48), .V_ACTIVE(32), .BOARD_X0(8), .CELL_PX(4),
        .H_FRONT(4), .H_SYNC(6), .H_BACK(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_color(wr_color), .cur_row(cur_row), .cur_col(cur_col), .pix_tick(s_pix_tick),
        .hsync(s_hsync), .vsync(s_vsync), .blank(s_blank), .color(s_color),
        .frame_start(s_frame_start)
    );

    vga_board_scan u_full (
        .clk(clk), .rst_n(rst_n_d), .wr_en(d_wr_en), .wr_row(d_zero), .wr_col(d_zero),
        .wr_color(d_zero), .cur_row(d_zero), .cur_col(d_zero), .pix_tick(d_pix_tick),
        .hsync(d_hsync), .vsync(d_vsync), .blank(d_blank), .color(d_color),
        .frame_start(d_frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int         key;
        int         fr;
        int         x;
        int         y;
        logic [2:0] color;
        logic       blank;
    } exp_t;

    exp_t sq[$];
    exp_t dq[$];

    function automatic void push_s(input int f, input int x, input int y,
                                   input logic [2:0] c, input logic b);
        exp_t e;
        e.key = f * 100000 + y * SH + x;
        e.fr = f; e.x = x; e.y = y; e.color = c; e.blank = b;
        sq.push_back(e);
    endfunction

    function automatic void push_d(input int f, input int x, input int y,
                                   input logic [2:0] c, input logic b);
        exp_t e;
        e.key = f * 1000000 + y * DH + x;
        e.fr = f; e.x = x; e.y = y; e.color = c; e.blank = b;
        dq.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- small-raster monitor ----------------
    int   s_fr = 0, s_x = 0, s_y = 0, s_idx = 0;
    logic s_sync = 1'b0;
    int   s_last_fs = -1, s_hfall = -1, s_vfall = -1, s_hlow = 0, s_vlow = 0;
    logic s_prev_h = 1'b1, s_prev_v = 1'b1;

    initial begin : mon_small
        int   key;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_sync = 1'b0; s_last_fs = -1; s_hfall = -1; s_vfall = -1;
                s_hlow = 0; s_vlow = 0; s_prev_h = 1'b1; s_prev_v = 1'b1; s_idx = 0;
            end else if (!s_pix_tick) begin
                if (s_frame_start) begin
                    if (s_last_fs >= 0) check("s_frame_period_clk", cyc - s_last_fs, SFRAME_CLK);
                    s_last_fs = cyc;
                    s_fr++; s_x = 0; s_y = 0; s_sync = 1'b1;
                end else if (s_sync) begin
                    s_x++;
                    if (s_x == SH) begin
                        s_x = 0; s_y++;
                        if (s_y == SV) s_y = 0;
                    end
                    if (s_x == 0 && s_y == 0) begin
                        checks++; errors++;
                        $display("FAIL s_frame_start: got 0, expected 1 at frame wrap (frame %0d)", s_fr);
                    end
                end
                if (s_sync) begin
                    s_idx++;
                    key = s_fr * 100000 + s_y * SH + s_x;
                    while (sq.size() > 0 && sq[0].key <= key) begin
                        e = sq.pop_front();
                        if (e.key != key) begin
                            checks++; errors++;
                            $display("FAIL s_pixel f%0d x%0d y%0d: never presented, expected color %0d",
                                     e.fr, e.x, e.y, e.color);
                        end else begin
                            check($sformatf("s_color f%0d x%0d y%0d", e.fr, e.x, e.y), s_color, e.color);
                            check($sformatf("s_blank f%0d x%0d y%0d", e.fr, e.x, e.y), s_blank, e.blank);
                        end
                    end
                    if (s_fr <= 2) begin
                        if (s_prev_h && !s_hsync) begin
                            check("s_hsync_fall_x", s_x, 52);
                            if (s_hfall >= 0) check("s_hsync_period", s_idx - s_hfall, SH);
                            s_hfall = s_idx;
                        end
                        if (!s_prev_h && s_hsync) begin
                            check("s_hsync_width", s_hlow, 6);
                            s_hlow = 0;
                        end
                        if (!s_hsync) s_hlow++;
                        if (s_prev_v && !s_vsync) begin
                            check("s_vsync_fall_pos", s_y * SH + s_x, 34 * SH);
                            if (s_vfall >= 0) check("s_vsync_period", s_idx - s_vfall, SH * SV);
                            s_vfall = s_idx;
                        end
                        if (!s_prev_v && s_vsync) begin
                            check("s_vsync_width", s_vlow, 2 * SH);
                            s_vlow = 0;
                        end
                        if (!s_vsync) s_vlow++;
                    end
                    s_prev_h = s_hsync;
                    s_prev_v = s_vsync;
                end
            end
        end
    end

    // ---------------- full-size monitor (first lines of frame 1) ----------------
    int   d_fr = 0, d_x = 0, d_y = 0, d_idx = 0, d_hfall = -1, d_hlow = 0;
    logic d_sync = 1'b0, d_prev_h = 1'b1;

    initial begin : mon_full
        int   key;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n_d && !d_pix_tick) begin
                if (d_frame_start) begin
                    d_fr++; d_x = 0; d_y = 0; d_sync = 1'b1;
                end else if (d_sync) begin
                    d_x++;
                    if (d_x == DH) begin
                        d_x = 0; d_y++;
                    end
                end
                if (d_sync) begin
                    d_idx++;
                    key = d_fr * 1000000 + d_y * DH + d_x;
                    while (dq.size() > 0 && dq[0].key <= key) begin
                        e = dq.pop_front();
                        if (e.key != key) begin
                            checks++; errors++;
                            $display("FAIL d_pixel f%0d x%0d y%0d: never presented, expected color %0d",
                                     e.fr, e.x, e.y, e.color);
                        end else begin
                            check($sformatf("d_color x%0d y%0d", e.x, e.y), d_color, e.color);
                            check($sformatf("d_blank x%0d y%0d", e.x, e.y), d_blank, e.blank);
                        end
                    end
                    if (d_fr == 1 && d_y < 3) begin
                        if (d_prev_h && !d_hsync) begin
                            check("d_hsync_fall_x", d_x, 656);
                            if (d_hfall >= 0) check("d_hsync_period", d_idx - d_hfall, 800);
                            d_hfall = d_idx;
                        end
                        if (!d_prev_h && d_hsync) begin
                            check("d_hsync_width", d_hlow, 96);
                            d_hlow = 0;
                        end
                        if (!d_hsync) d_hlow++;
                    end
                    d_prev_h = d_hsync;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pos(input int f, input int y, input int x);
        int n;
        n = 0;
        while (!(s_sync && s_fr == f && s_y == y && s_x == x)) begin
            @(negedge clk);
            #2;
            n++;
            if (n > 12000) begin
                checks++; errors++;
                $display("FAIL wait_pos f%0d y%0d x%0d: not reached within 12000 clk", f, y, x);
                return;
            end
        end
    endtask

    task automatic wr(input logic [2:0] r, input logic [2:0] c, input logic [2:0] v);
        @(posedge clk);
        #1;
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_color = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_tick"}, s_pix_tick, 0);
        check({tag, "_hsync"}, s_hsync, 1);
        check({tag, "_vsync"}, s_vsync, 1);
        check({tag, "_blank"}, s_blank, 1);
        check({tag, "_color"}, s_color, 0);
        check({tag, "_frame_start"}, s_frame_start, 0);
    endtask

    initial begin : stim
        int n;
        rst_n = 1'b0; rst_n_d = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_color = '0;
        cur_row = 3'd0; cur_col = 3'd0;
        d_wr_en = 1'b0; d_zero = 3'd0;

        // Full-size raster, empty board, cursor (0,0)
        push_d(1, 0, 0, 3'd0, 1'b0);   push_d(1, 79, 0, 3'd0, 1'b0);
        push_d(1, 80, 0, 3'd2, 1'b0);  push_d(1, 139, 0, 3'd2, 1'b0);
        push_d(1, 140, 0, 3'd1, 1'b0); push_d(1, 559, 0, 3'd1, 1'b0);
        push_d(1, 560, 0, 3'd0, 1'b0); push_d(1, 639, 0, 3'd0, 1'b0);
        push_d(1, 640, 0, 3'd0, 1'b1);
        push_d(1, 80, 30, 3'd2, 1'b0); push_d(1, 100, 30, 3'd0, 1'b0);
        push_d(1, 140, 30, 3'd1, 1'b0);

        // Small raster frame 1: grid line row 0, writes to (3,5), (6,1), (6,2)
        push_s(1, 0, 0, 3'd0, 1'b0);  push_s(1, 7, 0, 3'd0, 1'b0);
        push_s(1, 8, 0, 3'd2, 1'b0);  push_s(1, 11, 0, 3'd2, 1'b0);
        push_s(1, 12, 0, 3'd1, 1'b0); push_s(1, 39, 0, 3'd1, 1'b0);
        push_s(1, 40, 0, 3'd0, 1'b0); push_s(1, 47, 0, 3'd0, 1'b0);
        push_s(1, 48, 0, 3'd0, 1'b1); push_s(1, 10, 2, 3'd0, 1'b0);
        push_s(1, 28, 14, 3'd1, 1'b0); push_s(1, 30, 14, 3'd6, 1'b0);
        push_s(1, 40, 14, 3'd0, 1'b0); push_s(1, 14, 26, 3'd5, 1'b0);
        push_s(1, 18, 26, 3'd7, 1'b0); push_s(1, 8, 31, 3'd1, 1'b0);
        push_s(1, 8, 32, 3'd0, 1'b1); push_s(1, 30, 33, 3'd0, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1; rst_n_d = 1'b1;
        @(posedge clk);
        #1;
        check("por_pix_tick_1clk", s_pix_tick, 1);
        check("por_frame_start_1clk", s_frame_start, 0);
        @(posedge clk);
        #1;
        check("por_pix_tick_2clk", s_pix_tick, 0);
        check("por_frame_start_2clk", s_frame_start, 1);

        wr(3'd3, 3'd5, 3'd6);
        // back-to-back writes: (6,1) twice, last wins; then (6,2)
        @(posedge clk); #1; wr_en = 1'b1; wr_row = 3'd6; wr_col = 3'd1; wr_color = 3'd3;
        @(posedge clk); #1; wr_color = 3'd5;
        @(posedge clk); #1; wr_col = 3'd2; wr_color = 3'd7;
        @(posedge clk); #1; wr_en = 1'b0;

        // Frame 2: write (7,7)=4 while the beam is inside that cell
        push_s(2, 37, 30, 3'd0, 1'b0); push_s(2, 38, 30, 3'd4, 1'b0);
        push_s(2, 39, 30, 3'd4, 1'b0); push_s(2, 37, 31, 3'd4, 1'b0);
        wait_pos(2, 30, 36);
        wr(3'd7, 3'd7, 3'd4);
        cur_row = 3'd2; cur_col = 3'd2;

        // Frame 3: cursor moves (2,2)->(2,3) at line 9; (7,7) keeps its value
        push_s(3, 16, 8, 3'd2, 1'b0);  push_s(3, 17, 8, 3'd2, 1'b0);
        push_s(3, 20, 8, 3'd1, 1'b0);  push_s(3, 21, 8, 3'd1, 1'b0);
        push_s(3, 16, 9, 3'd1, 1'b0);  push_s(3, 20, 9, 3'd2, 1'b0);
        push_s(3, 24, 9, 3'd1, 1'b0);  push_s(3, 16, 10, 3'd1, 1'b0);
        push_s(3, 20, 10, 3'd2, 1'b0); push_s(3, 21, 10, 3'd0, 1'b0);
        push_s(3, 37, 28, 3'd1, 1'b0); push_s(3, 37, 29, 3'd4, 1'b0);
        push_s(3, 39, 29, 3'd4, 1'b0);
        wait_pos(3, 9, 2);
        cur_col = 3'd3;

        // Frame 4: reset mid-frame, then the next frame must show a cleared board
        wait_pos(4, 20, 30);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        push_s(5, 20, 8, 3'd2, 1'b0);  push_s(5, 30, 14, 3'd0, 1'b0);
        push_s(5, 14, 26, 3'd0, 1'b0); push_s(5, 18, 26, 3'd0, 1'b0);
        push_s(5, 37, 29, 3'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_color_held", s_color, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_frame_start_1clk", s_frame_start, 0);
        @(posedge clk);
        #1;
        check("mid_frame_start_2clk", s_frame_start, 1);
        @(posedge clk);
        #1;
        check("mid_frame_start_3clk", s_frame_start, 0);

        n = 0;
        while ((sq.size() > 0 || dq.size() > 0) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        while (sq.size() > 0) begin
            exp_t e;
            e = sq.pop_front();
            checks++; errors++;
            $display("FAIL s_pixel f%0d x%0d y%0d: not reached, expected color %0d", e.fr, e.x, e.y, e.color);
        end
        while (dq.size() > 0) begin
            exp_t e;
            e = dq.pop_front();
            checks++; errors++;
            $display("FAIL d_pixel f%0d x%0d y%0d: not reached, expected color %0d", e.fr, e.x, e.y, e.color);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
